// File: rtl/text_console_if.sv
// Character stream into the text console: one character plus foreground colour per
// valid/ready handshake.
interface text_console_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;
   logic [7:0] fg_r;
   logic [7:0] fg_g;
   logic [7:0] fg_b;

   modport master (output in_valid, in_char, fg_r, fg_g, fg_b, input in_ready);
   modport slave  (input in_valid, in_char, fg_r, fg_g, fg_b, output in_ready);
endinterface

// File: rtl/text_console.sv
// Text console: turns a character stream into four-page VRAM byte writes (char, R, G, B)
// and tracks the cursor. TEXT_CONSOLE_AUTOWRAP_EN wraps the cursor past the last column.
module text_console #(
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 60,
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   text_console_if.slave         in_if,
   output logic                  cpu_we,
   output logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [7:0]            cpu_wdata,
   output logic [6:0]            cursor_col,
   output logic [5:0]            cursor_row,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_CHAR = 3'd1,
      WR_R    = 3'd2,
      WR_G    = 3'd3,
      WR_B    = 3'd4,
      CLEAR   = 3'd5
   } state_t;

   localparam int unsigned PAGE_SIZE = COLS * ROWS;
   localparam logic [ADDR_WIDTH-1:0] PAGE1_A = ADDR_WIDTH'(PAGE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] PAGE2_A = ADDR_WIDTH'(2 * PAGE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] PAGE3_A = ADDR_WIDTH'(3 * PAGE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(4 * PAGE_SIZE - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CLR_CHAR = 8'h20;
   localparam logic [7:0] CLR_COL  = 8'hFF;

   state_t                  state;
   logic [7:0]              r_q, g_q, b_q;
   logic                    in_ready_q;
   logic                    accept;
   logic [ADDR_WIDTH-1:0]   cell_off;
   logic [ADDR_WIDTH-1:0]   clr_next;

   assign in_if.in_ready = in_ready_q;
   assign accept         = in_if.in_valid && in_ready_q;
   assign cell_off       = ADDR_WIDTH'(cursor_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(cursor_col);
   assign clr_next       = cpu_addr + ADDR_WIDTH'(1);

   // Sequencer: the state names the VRAM write currently presented on cpu_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cursor_col <= '0;
         cursor_row <= '0;
         cpu_we     <= 1'b0;
         cpu_addr   <= '0;
         cpu_wdata  <= '0;
         in_ready_q <= 1'b0;
         busy       <= 1'b0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (in_if.in_char >= CH_SPACE && in_if.in_char <= CH_TILDE) begin
                     state      <= WR_CHAR;
                     cpu_we     <= 1'b1;
                     cpu_addr   <= cell_off;
                     cpu_wdata  <= in_if.in_char;
                     r_q        <= in_if.fg_r;
                     g_q        <= in_if.fg_g;
                     b_q        <= in_if.fg_b;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b1;
                  end else begin
                     case (in_if.in_char)
                        CH_CR: cursor_col <= '0;
                        CH_LF: cursor_row <= (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
                        CH_BS: if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
                        CH_FF: begin
                           state      <= CLEAR;
                           cpu_we     <= 1'b1;
                           cpu_addr   <= '0;
                           cpu_wdata  <= CLR_CHAR;
                           in_ready_q <= 1'b0;
                           busy       <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            WR_CHAR: begin
               state     <= WR_R;
               cpu_addr  <= cell_off + PAGE1_A;
               cpu_wdata <= r_q;
            end
            WR_R: begin
               state     <= WR_G;
               cpu_addr  <= cell_off + PAGE2_A;
               cpu_wdata <= g_q;
            end
            WR_G: begin
               state     <= WR_B;
               cpu_addr  <= cell_off + PAGE3_A;
               cpu_wdata <= b_q;
            end
            WR_B: begin
               state      <= IDLE;
               cpu_we     <= 1'b0;
               in_ready_q <= 1'b1;
               busy       <= 1'b0;
               if (cursor_col != LAST_COL) begin
                  cursor_col <= cursor_col + 7'd1;
               end else begin
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
                  cursor_col <= '0;
                  cursor_row <= (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
`else
                  cursor_col <= cursor_col;
`endif
               end
            end
            CLEAR: begin
               if (cpu_addr == LAST_A) begin
                  state      <= IDLE;
                  cpu_we     <= 1'b0;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b0;
                  cursor_col <= '0;
                  cursor_row <= '0;
               end else begin
                  cpu_addr  <= clr_next;
                  cpu_wdata <= (clr_next < PAGE1_A) ? CLR_CHAR : CLR_COL;
               end
            end
            default: begin
               state      <= IDLE;
               cpu_we     <= 1'b0;
               in_ready_q <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: printable writes, control codes, clear, wrap and reset abort.
module tb_text_console;
   localparam int unsigned COLS = 80;
   localparam int unsigned ROWS = 60;
   localparam int unsigned AW   = 15;
   localparam int unsigned PAGE = COLS * ROWS;

   logic          clk;
   logic          rst_n;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [6:0]    cursor_col;
   logic [5:0]    cursor_row;
   logic          busy;

   text_console_if in_if ();

   text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (in_if),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   int         vec    = 0;
   int         miss   = 0;
   int         wr_cnt = 0;
   logic [7:0] vram [0:4*PAGE-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM model: captures whatever the console writes.
   always @(posedge clk) begin
      if (rst_n && cpu_we) begin
         vram[cpu_addr] = cpu_wdata;
         wr_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cur(input int c, input int r);
      return 32'({7'(c), 6'(r)});
   endfunction

   function automatic logic [31:0] cur_now();
      return 32'({cursor_col, cursor_row});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
      in_if.in_valid = 1'b1;
      in_if.in_char  = c;
      in_if.fg_r     = r;
      in_if.fg_g     = g;
      in_if.fg_b     = b;
      tick();
      in_if.in_valid = 1'b0;
   endtask

   task automatic put(input logic [7:0] c);
      send(c, 8'h00, 8'h00, 8'h00);
      repeat (4) tick();
   endtask

   initial begin
      int         w0;
      int         errs;
      int         exp_col;
      int         exp_row;
      int         exp_y_addr;
      logic [7:0] ctl [4];
      int         ctl_col [4];
      int         ctl_row [4];

      rst_n          = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_char  = 8'h00;
      in_if.fg_r     = 8'h00;
      in_if.fg_g     = 8'h00;
      in_if.fg_b     = 8'h00;

      // Reset state
      tick();
      chk("rst_we", 32'(cpu_we), 32'd0);
      chk("rst_addr", 32'(cpu_addr), 32'd0);
      chk("rst_wdata", 32'(cpu_wdata), 32'd0);
      chk("rst_ready", 32'(in_if.in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cursor", cur_now(), cur(0, 0));
      rst_n = 1'b1;
      chk("ready_pre_edge", 32'(in_if.in_ready), 32'd0);
      tick();
      chk("ready_after_rst", 32'(in_if.in_ready), 32'd1);

      // 'A' with colour 10/20/30 hex
      w0 = wr_cnt;
      send(8'h41, 8'h10, 8'h20, 8'h30);
      chk("a_ready_low", 32'(in_if.in_ready), 32'd0);
      chk("a_busy", 32'(busy), 32'd1);
      chk("a_w0", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd0, 32'h41}, 32'd1);
      tick();
      chk("a_w1", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd4800, 32'h10}, 32'd1);
      tick();
      chk("a_w2", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd9600, 32'h20}, 32'd1);
      tick();
      chk("a_w3", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd14400, 32'h30}, 32'd1);
      chk("a_cursor_stable", cur_now(), cur(0, 0));
      tick();
      chk("a_we_low", 32'(cpu_we), 32'd0);
      chk("a_ready_n5", 32'(in_if.in_ready), 32'd1);
      chk("a_busy_low", 32'(busy), 32'd0);
      chk("a_cursor", cur_now(), cur(1, 0));
      chk("a_addr_hold", 32'(cpu_addr), 32'd14400);
      chk("a_wr_count", 32'(wr_cnt - w0), 32'd4);

      // Inputs change mid-sequence while in_valid stays high
      in_if.in_valid = 1'b1;
      in_if.in_char  = 8'h51;
      in_if.fg_r     = 8'h01;
      in_if.fg_g     = 8'h02;
      in_if.fg_b     = 8'h03;
      tick();
      chk("hold_w0", {32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'h51}, 32'd1);
      in_if.in_char = 8'h52;
      in_if.fg_r    = 8'h99;
      in_if.fg_g    = 8'h99;
      in_if.fg_b    = 8'h99;
      tick();
      chk("hold_w1", {32'(cpu_addr), 32'(cpu_wdata)} == {32'd4801, 32'h01}, 32'd1);
      in_if.in_char = 8'h53;
      tick();
      chk("hold_w2", {32'(cpu_addr), 32'(cpu_wdata)} == {32'd9601, 32'h02}, 32'd1);
      tick();
      chk("hold_w3", {32'(cpu_addr), 32'(cpu_wdata)} == {32'd14401, 32'h03}, 32'd1);
      tick();
      in_if.in_valid = 1'b0;
      chk("hold_cursor", cur_now(), cur(2, 0));
      chk("hold_vram_char", 32'(vram[1]), 32'h51);

      // Printable range boundaries, then move to (5,3)
      send(8'h7E, 8'h00, 8'h00, 8'h00);
      chk("tilde_w0", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd2, 32'h7E}, 32'd1);
      repeat (4) tick();
      send(8'h20, 8'h00, 8'h00, 8'h00);
      chk("space_w0", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd3, 32'h20}, 32'd1);
      repeat (4) tick();
      put(8'h21);
      repeat (3) send(8'h0A, 8'h00, 8'h00, 8'h00);
      chk("pos_5_3", cur_now(), cur(5, 3));

      // CR, LF, BS, BS back to back
      ctl[0] = 8'h0D; ctl_col[0] = 0; ctl_row[0] = 3;
      ctl[1] = 8'h0A; ctl_col[1] = 0; ctl_row[1] = 4;
      ctl[2] = 8'h08; ctl_col[2] = 0; ctl_row[2] = 4;
      ctl[3] = 8'h08; ctl_col[3] = 0; ctl_row[3] = 4;
      w0 = wr_cnt;
      in_if.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_if.in_char = ctl[i];
         tick();
         chk($sformatf("ctl%0d_ready", i), 32'(in_if.in_ready), 32'd1);
         chk($sformatf("ctl%0d_cursor", i), cur_now(), cur(ctl_col[i], ctl_row[i]));
      end
      in_if.in_valid = 1'b0;
      chk("ctl_no_writes", 32'(wr_cnt - w0), 32'd0);

      // Discarded codes
      w0 = wr_cnt;
      send(8'h7F, 8'h00, 8'h00, 8'h00);
      send(8'h00, 8'h00, 8'h00, 8'h00);
      send(8'h1B, 8'h00, 8'h00, 8'h00);
      send(8'hFF, 8'h00, 8'h00, 8'h00);
      chk("disc_cursor", cur_now(), cur(0, 4));
      chk("disc_ready", 32'(in_if.in_ready), 32'd1);
      chk("disc_no_writes", 32'(wr_cnt - w0), 32'd0);

      // Backspace from a nonzero column
      put(8'h78);
      chk("bs_pre", cur_now(), cur(1, 4));
      send(8'h08, 8'h00, 8'h00, 8'h00);
      chk("bs_post", cur_now(), cur(0, 4));

      // Full clear
      w0 = wr_cnt;
      send(8'h0C, 8'h00, 8'h00, 8'h00);
      errs = 0;
      for (int i = 0; i < 4 * PAGE; i++) begin
         if (!(cpu_we === 1'b1 && 32'(cpu_addr) == 32'(i) &&
               cpu_wdata === ((i < PAGE) ? 8'h20 : 8'hFF) &&
               in_if.in_ready === 1'b0 && busy === 1'b1 &&
               cur_now() == cur(0, 4)))
            errs++;
         tick();
      end
      chk("clr_seq_errs", 32'(errs), 32'd0);
      chk("clr_we_low", 32'(cpu_we), 32'd0);
      chk("clr_ready", 32'(in_if.in_ready), 32'd1);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_cursor", cur_now(), cur(0, 0));
      chk("clr_count", 32'(wr_cnt - w0), 32'd19200);
      chk("clr_4799", 32'(vram[4799]), 32'h20);
      chk("clr_4800", 32'(vram[4800]), 32'hFF);
      chk("clr_addr_hold", 32'(cpu_addr), 32'd19199);

      // Last cell and wrap behaviour
      repeat (59) send(8'h0A, 8'h00, 8'h00, 8'h00);
      repeat (79) put(8'h2E);
      chk("pos_79_59", cur_now(), cur(79, 59));
      send(8'h5A, 8'h00, 8'h00, 8'h00);
      chk("z_w0", {32'(cpu_we), 32'(cpu_addr), 32'(cpu_wdata)} == {32'd1, 32'd4799, 32'h5A}, 32'd1);
      repeat (4) tick();
`ifdef TEXT_CONSOLE_AUTOWRAP_EN
      exp_col    = 0;
      exp_row    = 0;
      exp_y_addr = 0;
`else
      exp_col    = 79;
      exp_row    = 59;
      exp_y_addr = 4799;
`endif
      chk("z_cursor", cur_now(), cur(exp_col, exp_row));
      put(8'h59);
      chk("y_vram", 32'(vram[exp_y_addr]), 32'h59);

      // Reset in the middle of a clear
      send(8'h0C, 8'h00, 8'h00, 8'h00);
      repeat (1000) tick();
      chk("rc_at_1000", {32'(cpu_we), 32'(cpu_addr)} == {32'd1, 32'd1000}, 32'd1);
      rst_n = 1'b0;
      #1;
      w0 = wr_cnt;
      chk("rc_we_async", 32'(cpu_we), 32'd0);
      chk("rc_addr", 32'(cpu_addr), 32'd0);
      chk("rc_busy", 32'(busy), 32'd0);
      chk("rc_ready", 32'(in_if.in_ready), 32'd0);
      chk("rc_cursor", cur_now(), cur(0, 0));
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("rc_no_writes", 32'(wr_cnt - w0), 32'd0);
      chk("rc_ready_back", 32'(in_if.in_ready), 32'd1);
      chk("rc_idle_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns.
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows.
REQ-003 SHALL have parameter ADDR_WIDTH, default 15, meaning VRAM byte-address width; 4*COLS*ROWS SHALL fit in it.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, character offered.
REQ-007 SHALL have port in_ready, output, 1, character accepted when in_valid && in_ready.
REQ-008 SHALL have port in_char, input, 8, character code.
REQ-009 SHALL have ports fg_r, fg_g and fg_b, input, 8 each, colour captured with the character.
REQ-010 SHALL have port cpu_we, output, 1, VRAM write strobe.
REQ-011 SHALL have port cpu_addr, output, ADDR_WIDTH, VRAM byte address.
REQ-012 SHALL have port cpu_wdata, output, 8, VRAM write data.
REQ-013 SHALL have port cursor_col, output, 7, current column.
REQ-014 SHALL have port cursor_row, output, 6, current row.
REQ-015 SHALL have port busy, output, 1, high in any non-IDLE state.

Function
REQ-016 SHALL use PAGE_SIZE = COLS*ROWS and cell offset = cursor_row*COLS + cursor_col.
- Page 0 is the character, page 1 is R, page 2 is G, page 3 is B, each at page*PAGE_SIZE + offset.
REQ-017 SHALL implement the FSM states IDLE, WR_CHAR, WR_R, WR_G, WR_B and CLEAR; in_ready SHALL equal (state==IDLE).
REQ-018 SHALL register in_char, fg_r, fg_g and fg_b on acceptance, so later input changes do not affect the transaction.
REQ-019 SHALL handle a printable character (0x20-0x7E) accepted in cycle N as follows:
- One write per cycle in N+1..N+4, in the order char, R, G, B.
- cpu_we is high in those four cycles only.
- The cursor advances at the end of N+4.
- in_ready is high again in N+5.
REQ-020 SHALL treat 0x0D (CR) as: cursor_col=0, no write, and ready again the next cycle.
REQ-021 SHALL treat 0x0A (LF) as: cursor_row+1, wrapping from ROWS-1 to 0 with no scrolling; cursor_col is unchanged; no write.
REQ-022 SHALL treat 0x08 (BS) as: cursor_col-1 if nonzero, else no change; no write.
REQ-023 SHALL treat 0x0C (FF) as a full clear:
- Enter CLEAR and write cpu_addr = 0 .. 4*PAGE_SIZE-1, incrementing by 1 per cycle with cpu_we high.
- cpu_wdata is 0x20 for addresses below PAGE_SIZE, else 0xFF.
- Afterwards the cursor is (0,0) and the FSM returns to IDLE.
REQ-024 SHALL accept and discard all other codes (0x00-0x1F not listed above, and 0x7F-0xFF) with no write and no cursor change.
REQ-025 SHALL keep cpu_we low, and cpu_addr and cpu_wdata holding their last values, while in IDLE.
REQ-026 SHALL keep cursor_col and cursor_row stable throughout a write sequence.

Reset
REQ-027 SHALL, while rst_n is low, immediately force:
- state=IDLE, cursor (0,0);
- cpu_we=0, cpu_addr=0, cpu_wdata=0;
- in_ready=0, busy=0.
REQ-028 SHALL raise in_ready in the first clock after rst_n deasserts.
REQ-029 SHALL abort an in-progress write or clear on reset with no further writes; VRAM contents are left partially updated.

Configuration
REQ-030 SHALL support macro TEXT_CONSOLE_AUTOWRAP_EN.
- Defined: a printable character at column COLS-1 moves the cursor to column 0 of the next row, and row ROWS-1 wraps to row 0.
- Undefined: the cursor stays at COLS-1, and later printables overwrite that last cell.
- All other behaviour is identical in both builds.

Verification
REQ-031 SHALL cover: after reset, accept 'A' (0x41) with fg=10/20/30 -> writes (0,0x41),(4800,0x10),(9600,0x20),(14400,0x30) on consecutive cycles, cursor (1,0), in_ready high 5 cycles after acceptance.
REQ-032 SHALL cover: cursor (5,3), then CR, LF, BS, BS -> cursor (0,4), zero writes, 4 transactions in 4 cycles.
REQ-033 SHALL cover: FF -> 19200 consecutive writes, addr 4799 data 0x20, addr 4800 data 0xFF, in_ready low throughout, cursor (0,0) at the end.
REQ-034 SHALL cover: cursor (79,59), printable 'Z' -> with AUTOWRAP_EN cursor (0,0); without it cursor (79,59), and a second 'Z' rewrites addr 4799.
REQ-035 SHALL cover: rst_n low for 1 cycle during CLEAR at addr 1000 -> cpu_we drops asynchronously, cursor (0,0), no writes after reset.
REQ-036 SHALL cover: in_valid held with in_char changing during WR_R -> written data reflects the originally accepted character only.
